joy_socd_filter: RTL and testbench
==================================

// Module: joy_socd_filter
// PURPOSE
// - Multi-player joystick conditioner between hps_io joystick words / keyboard direction regs and the game input muxes.
// - Replaces the per-player 2-way L/R resolver: resolves L+R and U+D conflicts (SOCD) per player under a runtime-selectable policy.
// - Optionally restricts output to 4-way (no diagonals) for 4-way arcade cabinets.
// - All state is registered; output is glitch-free and synchronous to clk.
// PARAMETERS
// - NUM_PLAYERS  2   number of players; each owns one 4-bit direction nibble
// - SYNC_STAGES  2   input synchroniser depth, >=1
// - DEB_CYCLES   16  debounce stability window in clk cycles (used only with JOY_SOCD_DEBOUNCE_EN), >=1
// PORTS
// - clk        in   1              system clock (clk_sys)
// - reset      in   1              synchronous, active-high reset
// - mode       in   2              SOCD policy: 0=last-wins 1=neutral 2=first-wins 3=passthrough
// - four_way   in   1              1=suppress diagonals (modes 0-2 only)
// - dir_in     in   4*NUM_PLAYERS  raw active-high dirs; player p nibble [4p+3:4p] = {U,D,L,R}
// - dir_out    out  4*NUM_PLAYERS  resolved active-high dirs, same packing
// BEHAVIOUR
// - Reset: every sync/debounce/state register and dir_out = 0; newest-axis reg = H.
// - Stage 1: each dir_in bit passes SYNC_STAGES flops -> s. Latency dir_in->dir_out = SYNC_STAGES+1 cycles.
// - Per player, per axis (H={L,R}, V={U,D}); a = 2-bit s of axis, o = registered axis output, rise = a & ~a_prev:
//   - a=00 -> o<=00; a=01 or 10 -> o<=a.
//   - a=11, mode 0: rise=01 -> o<=01; rise=10 -> o<=10; rise=11 -> o<=00; rise=00 -> o holds.
//   - a=11, mode 1: o<=00.
//   - a=11, mode 2: o holds (both pressed same cycle from 00 -> stays 00).
//   - mode 3: o<=a (raw, no resolution, four_way ignored).
// - Four-way (four_way=1, mode!=3), per player, reg newest in {H,V}:
//   - axis "newly active" = its resolved value goes 00->nonzero or changes direction this cycle.
//   - only V newly active -> newest<=V; only H, or both same cycle -> newest<=H.
//   - both resolved axes nonzero -> output newest axis, other axis forced 00; else output both unchanged.
//   - newest updates even when four_way=0, so toggling four_way takes effect next cycle with no stale state.
// - Mode / four_way changes apply on the next clk; state registers are not cleared.
// - Players are fully independent; no cross-player interaction.
// - Reset mid-operation: all state cleared; an input still held after reset is seen as a fresh rise
//   (a_prev=0) and resolved accordingly (held L+R in mode 0 -> 00 until one side released/re-pressed).
// CONFIGURATION
// - JOY_SOCD_DEBOUNCE_EN defined: per-bit debouncer between synchroniser and resolver; stable bit changes only
//   after s differs from it for DEB_CYCLES consecutive cycles; counter clears on any agreement; latency +DEB_CYCLES.
// - Not defined: no debouncer, DEB_CYCLES unused, latency SYNC_STAGES+1.
// TESTING (NUM_PLAYERS=2, SYNC_STAGES=2, debounce off unless stated)
// - Reset, dir_in=8'hFF held: dir_out=00 during reset; 3 cycles after release mode 0 gives 8'h00 (both axes simultaneous rise).
// - Mode 0, P0: R=1, 5 cycles later L=1 -> P0 nibble 0001 then 0010 at 3 cycles after L; release L -> 0001.
// - Mode 1, P0 R then L held -> nibble 0000; mode 2 same stimulus -> stays 0001; mode 3 -> 0011.
// - four_way=1, P1: U held, then R pressed -> P1 nibble 1000 then 0001; release R -> 1000; P0 unaffected.
// - Mode switched 0->1 while L+R held with o=10 -> next resolved cycle 00; switch back to 0 -> holds 00 (no new rise).
// - JOY_SOCD_DEBOUNCE_EN, DEB_CYCLES=16: 10-cycle R pulse -> no output; 20-cycle pulse -> R asserted 2+16+1 cycles after press.

Source files
------------

// File: rtl/joy_socd_filter.sv
// Per-player SOCD resolver with optional 4-way restriction for joystick direction nibbles.
// Optional feature: define JOY_SOCD_DEBOUNCE_EN to insert a per-bit debouncer after the synchroniser.
module joy_socd_filter #(
    parameter int unsigned NUM_PLAYERS = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               mode,
    input  logic                     four_way,
    input  logic [4*NUM_PLAYERS-1:0] dir_in,
    output logic [4*NUM_PLAYERS-1:0] dir_out
);

    localparam int unsigned W = 4 * NUM_PLAYERS;
    localparam logic [1:0] MODE_LAST = 2'd0;
    localparam logic [1:0] MODE_NEUT = 2'd1;
    localparam logic [1:0] MODE_RAW  = 2'd3;

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] s;
    logic [W-1:0] a_cur;
    logic [W-1:0] a_prev;
    logic [W-1:0] o_q;
    logic [W-1:0] o_nxt;
    logic [W-1:0] out_nxt;
    logic [NUM_PLAYERS-1:0] newest_q;   // 1 = vertical axis pressed most recently
    logic [NUM_PLAYERS-1:0] newest_nxt;

    // input synchroniser
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= dir_in;
            for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef JOY_SOCD_DEBOUNCE_EN
    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] deb_cnt [W];
    logic [W-1:0]  deb_stable;

    // stable bit follows s only after DEB_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            deb_stable <= '0;
            for (int b = 0; b < int'(W); b++) deb_cnt[b] <= '0;
        end else begin
            for (int b = 0; b < int'(W); b++) begin
                if (s[b] == deb_stable[b]) begin
                    deb_cnt[b] <= '0;
                end else if (deb_cnt[b] == CW'(DEB_CYCLES - 1)) begin
                    deb_stable[b] <= s[b];
                    deb_cnt[b]    <= '0;
                end else begin
                    deb_cnt[b] <= deb_cnt[b] + CW'(1);
                end
            end
        end
    end

    assign a_cur = deb_stable;
`else
    assign a_cur = s;
`endif

    function automatic logic [1:0] resolve(input logic [1:0] a, input logic [1:0] ap,
                                           input logic [1:0] o, input logic [1:0] m);
        logic [1:0] rise;
        logic [1:0] r;
        rise = a & ~ap;
        r    = o;
        if (m == MODE_RAW || a != 2'b11) begin
            r = a;
        end else if (m == MODE_LAST) begin
            case (rise)
                2'b01:   r = 2'b01;
                2'b10:   r = 2'b10;
                2'b11:   r = 2'b00;
                default: r = o;
            endcase
        end else if (m == MODE_NEUT) begin
            r = 2'b00;
        end
        return r;
    endfunction

    // SOCD resolution and 4-way newest-axis selection, per player
    always_comb begin : resolve_comb
        logic [1:0] h;
        logic [1:0] v;
        logic       nh;
        logic       nv;
        logic       nw;
        o_nxt      = '0;
        out_nxt    = '0;
        newest_nxt = newest_q;
        for (int p = 0; p < int'(NUM_PLAYERS); p++) begin
            h  = resolve(a_cur[4*p +: 2], a_prev[4*p +: 2], o_q[4*p +: 2], mode);
            v  = resolve(a_cur[4*p+2 +: 2], a_prev[4*p+2 +: 2], o_q[4*p+2 +: 2], mode);
            nh = (h != 2'b00) && (h != o_q[4*p +: 2]);
            nv = (v != 2'b00) && (v != o_q[4*p+2 +: 2]);
            nw = newest_q[p];
            if (nh)      nw = 1'b0;
            else if (nv) nw = 1'b1;
            newest_nxt[p]     = nw;
            o_nxt[4*p +: 4]   = {v, h};
            out_nxt[4*p +: 4] = {v, h};
            if (four_way && mode != MODE_RAW && h != 2'b00 && v != 2'b00)
                out_nxt[4*p +: 4] = nw ? {v, 2'b00} : {2'b00, h};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_prev   <= '0;
            o_q      <= '0;
            newest_q <= '0;
            dir_out  <= '0;
        end else begin
            a_prev   <= a_cur;
            o_q      <= o_nxt;
            newest_q <= newest_nxt;
            dir_out  <= out_nxt;
        end
    end

endmodule

// File: tb/tb_joy_socd_filter.sv
// Scoreboard bench for joy_socd_filter: driver queues expected dir_out per cycle, monitor checks.
module tb_joy_socd_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       four_way;
    logic [7:0] dir_in;
    logic [7:0] dir_out;

    typedef struct {
        int         cyc;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    joy_socd_filter #(.NUM_PLAYERS(2), .SYNC_STAGES(2), .DEB_CYCLES(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .mode     (mode),
        .four_way (four_way),
        .dir_in   (dir_in),
        .dir_out  (dir_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: compare every queued expectation due this cycle
    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc) begin
                checks++;
                if (dir_out !== q[i].exp) begin
                    failures++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", q[i].name, cyc, dir_out, q[i].exp);
                end
                q.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int d, input logic [7:0] e, input string nm);
        exp_t x;
        x.cyc  = cyc + d;
        x.exp  = e;
        x.name = nm;
        q.push_back(x);
    endtask

    initial begin
        reset = 1'b1; mode = 2'd0; four_way = 1'b0; dir_in = 8'hFF;
        step(1);
        expect_at(0, 8'h00, "rst");
        step(3);
        expect_at(0, 8'h00, "rst_hold");
        reset = 1'b0;
        expect_at(3, 8'h00, "ff_simul_rise");
        expect_at(5, 8'h00, "ff_simul_hold");
        step(6);

`ifdef JOY_SOCD_DEBOUNCE_EN
        dir_in = 8'h00;
        step(30);
        dir_in = 8'h01;
        step(10);
        dir_in = 8'h00;
        expect_at(5, 8'h00, "deb_short_a");
        expect_at(15, 8'h00, "deb_short_b");
        expect_at(25, 8'h00, "deb_short_c");
        step(30);
        dir_in = 8'h01;
        expect_at(18, 8'h00, "deb_long_early");
        expect_at(19, 8'h01, "deb_long_on");
        step(20);
        dir_in = 8'h00;
        step(5);
`else
        // mode 0 last-wins on P0 horizontal
        dir_in = 8'h00; step(4);
        dir_in = 8'h01;
        expect_at(3, 8'h01, "m0_r");
        step(5);
        dir_in = 8'h03;
        expect_at(2, 8'h01, "m0_r_pre");
        expect_at(3, 8'h02, "m0_l_wins");
        step(4);
        dir_in = 8'h01;
        expect_at(3, 8'h01, "m0_rel_l");
        step(4);
        // mode 0 vertical: D then U
        dir_in = 8'h04; expect_at(3, 8'h04, "m0_d");
        step(4);
        dir_in = 8'h0C; expect_at(3, 8'h08, "m0_u_wins");
        step(4);

        // mode 1 neutral
        dir_in = 8'h00; step(4);
        mode = 2'd1;
        dir_in = 8'h01; expect_at(3, 8'h01, "m1_r");
        step(5);
        dir_in = 8'h03; expect_at(3, 8'h00, "m1_neutral");
        step(4);

        // mode 2 first-wins
        dir_in = 8'h00; step(4);
        mode = 2'd2;
        dir_in = 8'h01; expect_at(3, 8'h01, "m2_r");
        step(5);
        dir_in = 8'h03; expect_at(3, 8'h01, "m2_first_wins");
        step(4);
        // mode 3 passthrough, next clock, four_way ignored
        mode = 2'd3; expect_at(1, 8'h03, "m3_raw");
        step(2);
        four_way = 1'b1; dir_in = 8'h05; expect_at(3, 8'h05, "m3_diag");
        step(4);
        four_way = 1'b0;
        // mode 2 simultaneous press from idle
        dir_in = 8'h00; step(4);
        mode = 2'd2;
        dir_in = 8'h03; expect_at(3, 8'h00, "m2_simul");
        step(4);

        // four-way on P1 with P0 independent
        mode = 2'd0; four_way = 1'b1;
        dir_in = 8'h00; step(4);
        dir_in = 8'h81; expect_at(3, 8'h81, "4w_u");
        step(5);
        dir_in = 8'h91; expect_at(3, 8'h11, "4w_r_newest");
        step(4);
        dir_in = 8'h81; expect_at(3, 8'h81, "4w_rel_r");
        step(4);
        dir_in = 8'h91; expect_at(3, 8'h11, "4w_r_again");
        step(4);
        four_way = 1'b0; expect_at(1, 8'h91, "4w_off");
        step(2);
        four_way = 1'b1; expect_at(1, 8'h11, "4w_on");
        step(2);

        // mode switch while L+R held
        four_way = 1'b0; mode = 2'd0;
        dir_in = 8'h00; step(4);
        dir_in = 8'h01; step(5);
        dir_in = 8'h03; expect_at(3, 8'h02, "sw_l");
        step(5);
        mode = 2'd1; expect_at(1, 8'h00, "sw_neutral");
        step(2);
        mode = 2'd0;
        expect_at(1, 8'h00, "sw_back");
        expect_at(3, 8'h00, "sw_back_hold");
        step(4);

        // reset mid-operation with L+R held
        dir_in = 8'h00; step(4);
        dir_in = 8'h01; step(5);
        dir_in = 8'h03; expect_at(3, 8'h02, "mid_l");
        step(4);
        reset = 1'b1; expect_at(1, 8'h00, "mid_rst");
        step(2);
        reset = 1'b0; expect_at(3, 8'h00, "mid_rst_lr");
        step(5);
        dir_in = 8'h02; expect_at(3, 8'h02, "mid_rel_r");
        step(4);
`endif
        step(5);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending got=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
